// File: rtl/asu_writeback_stage.sv
// Writeback stage for the SAYAC add/subtract unit: derives Z/N/C/V for each result,
// buffers results in a 2-entry FIFO, and keeps the architectural flags and overflow trap.
module asu_writeback_stage #(
   parameter int WIDTH   = 16,
   parameter int REGADDR = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   asu_in1,
   input  logic [WIDTH-1:0]   asu_in2,
   input  logic [WIDTH-1:0]   asu_result,
   input  logic               arith_add,
   input  logic               arith_sub,
   input  logic [REGADDR-1:0] dest_in,
   input  logic               flush,
   input  logic               trap_en,
   output logic               wb_valid,
   input  logic               wb_ready,
   output logic [WIDTH-1:0]   wb_data,
   output logic [REGADDR-1:0] wb_dest,
   output logic [3:0]         wb_flags,
   output logic [3:0]         flag_reg,
   output logic               ovf_trap
);

   logic [WIDTH-1:0]   data_q  [2];
   logic [WIDTH-1:0]   data_d  [2];
   logic [REGADDR-1:0] dest_q  [2];
   logic [REGADDR-1:0] dest_d  [2];
   logic [3:0]         flags_q [2];
   logic [3:0]         flags_d [2];
   logic               wr_ptr_q, wr_ptr_d;
   logic               rd_ptr_q, rd_ptr_d;
   logic [1:0]         count_q, count_d;
   logic [3:0]         flag_reg_q, flag_reg_d;
   logic               ovf_trap_q, ovf_trap_d;

   logic               push, pop;
   logic               in_msb1, in_msb2, res_msb;
   logic               flag_c, flag_v;
   logic [3:0]         new_flags;

   assign in_ready = (count_q < 2'd2);
   assign wb_valid = (count_q != 2'd0);
   assign wb_data  = wb_valid ? data_q[rd_ptr_q]  : '0;
   assign wb_dest  = wb_valid ? dest_q[rd_ptr_q]  : '0;
   assign wb_flags = wb_valid ? flags_q[rd_ptr_q] : '0;
   assign flag_reg = flag_reg_q;
   assign ovf_trap = ovf_trap_q;

   assign push = in_valid && in_ready;
   assign pop  = wb_valid && wb_ready;

   assign in_msb1 = asu_in1[WIDTH-1];
   assign in_msb2 = asu_in2[WIDTH-1];
   assign res_msb = asu_result[WIDTH-1];

   always_comb begin
      flag_c = 1'b0;
      flag_v = 1'b0;
      // Carry-out of in1+in2 shows up as the WIDTH-bit wrapped sum falling below in1
      if (arith_add) begin
         flag_c = ((asu_in1 + asu_in2) < asu_in1);
         flag_v = (in_msb1 == in_msb2) && (res_msb != in_msb1);
      end else if (arith_sub) begin
         flag_c = (asu_in1 < asu_in2);
         flag_v = (in_msb1 != in_msb2) && (res_msb != in_msb1);
      end
      new_flags = {(asu_result == '0), res_msb, flag_c, flag_v};
   end

   always_comb begin
      data_d     = data_q;
      dest_d     = dest_q;
      flags_d    = flags_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      flag_reg_d = flag_reg_q;
      ovf_trap_d = 1'b0;
      if (flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = '0;
      end else begin
         if (push) begin
            data_d[wr_ptr_q]  = asu_result;
            dest_d[wr_ptr_q]  = dest_in;
            flags_d[wr_ptr_q] = new_flags;
            wr_ptr_d          = ~wr_ptr_q;
         end
         if (pop) begin
            flag_reg_d = flags_q[rd_ptr_q];
            ovf_trap_d = flags_q[rd_ptr_q][0] && trap_en;
            rd_ptr_d   = ~rd_ptr_q;
         end
         count_d = count_q + 2'(push) - 2'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q     <= '{default: '0};
         dest_q     <= '{default: '0};
         flags_q    <= '{default: '0};
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= '0;
         flag_reg_q <= '0;
         ovf_trap_q <= 1'b0;
      end else begin
         data_q     <= data_d;
         dest_q     <= dest_d;
         flags_q    <= flags_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         flag_reg_q <= flag_reg_d;
         ovf_trap_q <= ovf_trap_d;
      end
   end

endmodule

// File: tb/tb_asu_writeback_stage.sv
// Directed bench for asu_writeback_stage: queue-based reference model checked every
// cycle, plus literal expectations for the flag encodings and reset behaviour.
module tb_asu_writeback_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] asu_in1 = '0;
   logic [15:0] asu_in2 = '0;
   logic [15:0] asu_result = '0;
   logic        arith_add = 1'b0;
   logic        arith_sub = 1'b0;
   logic [3:0]  dest_in = '0;
   logic        flush = 1'b0;
   logic        trap_en = 1'b0;
   logic        wb_valid;
   logic        wb_ready = 1'b0;
   logic [15:0] wb_data;
   logic [3:0]  wb_dest;
   logic [3:0]  wb_flags;
   logic [3:0]  flag_reg;
   logic        ovf_trap;

   int vectors = 0;
   int miscompares = 0;

   asu_writeback_stage #(.WIDTH(16), .REGADDR(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .asu_in1(asu_in1), .asu_in2(asu_in2), .asu_result(asu_result),
      .arith_add(arith_add), .arith_sub(arith_sub), .dest_in(dest_in),
      .flush(flush), .trap_en(trap_en), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_data(wb_data), .wb_dest(wb_dest), .wb_flags(wb_flags),
      .flag_reg(flag_reg), .ovf_trap(ovf_trap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] d;
      logic [3:0]  dest;
      logic [3:0]  f;
   } ent_t;

   ent_t        mq[$];
   logic [3:0]  m_flag = '0;
   logic        m_trap = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Flags from true integer arithmetic: carry/borrow from unsigned range, V from signed range
   function automatic logic [3:0] model_flags(input logic [15:0] a, input logic [15:0] b,
                                              input logic [15:0] r, input logic ad, input logic sb);
      int unsigned ua = a;
      int unsigned ub = b;
      int sa = $signed(a);
      int sbv = $signed(b);
      int s;
      logic c = 1'b0;
      logic v = 1'b0;
      logic [15:0] rr = r;
      if (ad) begin
         s = sa + sbv;
         c = (ua + ub) > 65535;
         v = (s > 32767) || (s < -32768);
      end else if (sb) begin
         s = sa - sbv;
         c = ua < ub;
         v = (s > 32767) || (s < -32768);
      end
      return {(rr == 16'd0), rr[15], c, v};
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            mq.delete();
            m_flag = '0;
            m_trap = 1'b0;
         end else begin
            bit do_pop;
            bit do_push;
            ent_t e;
            do_pop  = (mq.size() > 0) && wb_ready;
            do_push = in_valid && (mq.size() < 2);
            m_trap  = 1'b0;
            if (flush) begin
               mq.delete();
            end else begin
               if (do_pop) begin
                  m_flag = mq[0].f;
                  m_trap = mq[0].f[0] && trap_en;
                  void'(mq.pop_front());
               end
               if (do_push) begin
                  e.d    = asu_result;
                  e.dest = dest_in;
                  e.f    = model_flags(asu_in1, asu_in2, asu_result, arith_add, arith_sub);
                  mq.push_back(e);
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("in_ready", in_ready, mq.size() < 2);
         chk("wb_valid", wb_valid, mq.size() > 0);
         chk("wb_data",  wb_data,  (mq.size() > 0) ? mq[0].d    : 16'd0);
         chk("wb_dest",  wb_dest,  (mq.size() > 0) ? mq[0].dest : 4'd0);
         chk("wb_flags", wb_flags, (mq.size() > 0) ? mq[0].f    : 4'd0);
         chk("flag_reg", flag_reg, m_flag);
         chk("ovf_trap", ovf_trap, m_trap);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Holds in_valid until the stage accepts; returns just after the accepting edge
   task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r,
                       input logic ad, input logic sb, input logic [3:0] d);
      bit ok = 0;
      in_valid = 1'b1; asu_in1 = a; asu_in2 = b; asu_result = r;
      arith_add = ad; arith_sub = sb; dest_in = d;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #2;
      end
      if (!ok) chk("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_wb_valid"}, wb_valid, 0);
      chk({tag, "_wb_data"},  wb_data,  0);
      chk({tag, "_wb_dest"},  wb_dest,  0);
      chk({tag, "_wb_flags"}, wb_flags, 0);
      chk({tag, "_flag_reg"}, flag_reg, 0);
      chk({tag, "_ovf_trap"}, ovf_trap, 0);
   endtask

   initial begin
      #12;
      chk_reset_outputs("rst0");
      tick();
      rst = 1'b1;
      tick();

      // single add, popped immediately
      wb_ready = 1'b1;
      push(16'd5, 16'd9, 16'd14, 1, 0, 4'd3);
      idle();
      chk("add_valid", wb_valid, 1);
      chk("add_data",  wb_data,  16'h000E);
      chk("add_dest",  wb_dest,  4'd3);
      chk("add_flags", wb_flags, 4'b0000);
      tick();
      chk("add_popped", wb_valid, 0);
      chk("add_flagreg", flag_reg, 4'b0000);

      push(16'd10, 16'd7, 16'd3, 0, 1, 4'd1);
      idle();
      chk("sub_pos_flags", wb_flags, 4'b0000);
      tick();
      push(16'd5, 16'd9, 16'hFFFC, 0, 1, 4'd2);
      idle();
      chk("sub_neg_flags", wb_flags, 4'b0110);
      tick();
      chk("sub_neg_flagreg", flag_reg, 4'b0110);

      // signed overflow with and without trap
      trap_en = 1'b1;
      push(16'h7FFF, 16'h0001, 16'h8000, 1, 0, 4'd4);
      idle();
      chk("ovf_flags", wb_flags, 4'b0101);
      tick();
      chk("ovf_trap_pulse", ovf_trap, 1);
      chk("ovf_flagreg", flag_reg, 4'b0101);
      tick();
      chk("ovf_trap_end", ovf_trap, 0);
      trap_en = 1'b0;
      push(16'h7FFF, 16'h0001, 16'h8000, 1, 0, 4'd5);
      idle();
      tick();
      chk("ovf_notrap", ovf_trap, 0);
      push(16'hFFFF, 16'h0001, 16'h0000, 1, 0, 4'd6);
      idle();
      chk("carry_zero_flags", wb_flags, 4'b1010);
      tick();

      // backpressure: third push held off until the sink drains
      wb_ready = 1'b0;
      fork
         begin
            push(16'h0101, 16'h0001, 16'h0102, 1, 0, 4'd7);
            push(16'h0202, 16'h0001, 16'h0203, 1, 0, 4'd8);
            push(16'h0303, 16'h0001, 16'h0304, 1, 0, 4'd9);
            idle();
         end
         begin
            repeat (3) @(posedge clk);
            #2;
            chk("full_in_ready", in_ready, 0);
            chk("full_head", wb_data, 16'h0102);
            wb_ready = 1'b1;
         end
      join
      tick();
      tick();
      tick();

      // push and pop together at count 1: newest entry becomes head
      push(16'd1, 16'd2, 16'd3, 1, 0, 4'd10);
      push(16'd3, 16'd4, 16'd7, 1, 0, 4'd11);
      chk("pp_head", wb_data, 16'd7);
      chk("pp_valid", wb_valid, 1);
      chk("pp_ready", in_ready, 1);
      push(16'd4, 16'd6, 16'hFFFE, 0, 1, 4'd12);
      idle();
      tick();
      chk("pp_flagreg", flag_reg, 4'b0110);

      // flush with two buffered entries; concurrent pop and push are ignored
      wb_ready = 1'b0;
      trap_en = 1'b1;
      push(16'h7FFF, 16'h0001, 16'h8000, 1, 0, 4'd13);
      push(16'd20, 16'd1, 16'd21, 1, 0, 4'd14);
      idle();
      flush = 1'b1;
      wb_ready = 1'b1;
      in_valid = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      wb_ready = 1'b0;
      chk("flush_valid", wb_valid, 0);
      chk("flush_ready", in_ready, 1);
      chk("flush_flagreg", flag_reg, 4'b0110);
      chk("flush_notrap", ovf_trap, 0);
      trap_en = 1'b0;

      push(16'd12, 16'd34, 16'd0, 0, 0, 4'd15);
      idle();
      chk("noop_flags", wb_flags, 4'b1000);
      wb_ready = 1'b1;
      tick();

      // asynchronous reset between edges with a full FIFO
      wb_ready = 1'b0;
      push(16'd1, 16'd1, 16'd2, 1, 0, 4'd1);
      push(16'd2, 16'd2, 16'd4, 1, 0, 4'd2);
      idle();
      #1 rst = 1'b0;
      #1;
      chk_reset_outputs("arst");
      tick();
      rst = 1'b1;
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/asu_writeback_stage.md
Name: asu_writeback_stage

Overview:
Downstream stage of the SAYAC add/subtract unit. It captures each ASU result together with its operands and op-select lines, and derives Z/N/C/V flags. Results are held in a 2-entry FIFO with a valid/ready handshake, so a stalled register-file write port does not drop ASU results. It also keeps an architectural flag register and an overflow-trap pulse for the control unit.

Parameters:
WIDTH, 16, datapath width of operands and result
REGADDR, 4, width of destination register index

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  ASU result presented this cycle
in_ready  output  1  stage can accept (FIFO not full)
asu_in1  input  WIDTH  first ASU operand
asu_in2  input  WIDTH  second ASU operand
asu_result  input  WIDTH  ASU output (outASU)
arith_add  input  1  ASU add select
arith_sub  input  1  ASU subtract select
dest_in  input  REGADDR  destination register index
flush  input  1  synchronous discard of all buffered entries
trap_en  input  1  enable overflow trap
wb_valid  output  1  head entry valid
wb_ready  input  1  register file accepts head entry
wb_data  output  WIDTH  head result
wb_dest  output  REGADDR  head destination
wb_flags  output  4  head flags {Z,N,C,V}
flag_reg  output  4  flags of last entry popped
ovf_trap  output  1  one-cycle pulse on popping an entry with V=1 while trap_en=1

Behaviour:
- Reset (rst=0, async): FIFO empty, count=0, rd/wr pointers=0, wb_valid=0, in_ready=1, wb_data=0, wb_dest=0, wb_flags=0, flag_reg=0, ovf_trap=0.
- Push when in_valid && in_ready. Pop when wb_valid && wb_ready. in_ready = (count<2) and depends only on registered state.
- Latency: an entry pushed into an empty FIFO at edge N appears on wb_* after edge N; there is no bypass.
- Simultaneous push and pop at count 1: count stays 1 and the new entry becomes head. At count 2, in_ready=0 so no push; a pop makes count 1.
- Head outputs reflect the oldest entry. When empty: wb_valid=0 and wb_data/dest/flags are 0.
- Flags are computed combinationally at push time from the inputs and stored with the entry:
  Z = (asu_result==0); N = asu_result[WIDTH-1].
  If arith_add=1 (takes priority over sub): C = carry-out of the (WIDTH+1)-bit sum asu_in1+asu_in2. V = (in1 msb == in2 msb) && (result msb != in1 msb).
  Else if arith_sub=1: C = borrow = (asu_in1 < asu_in2, unsigned). V = (in1 msb != in2 msb) && (result msb != in1 msb).
  Else: C=0, V=0 (result expected 0, so Z=1).
- asu_result is stored verbatim and is not recomputed or checked.
- On a pop: flag_reg <= head flags, and ovf_trap=1 for exactly that cycle if head V=1 and trap_en=1 (trap_en is sampled at the pop edge). Otherwise ovf_trap=0.
- flush=1: at the next edge count=0 and pointers=0. Any push or pop in that cycle is ignored, and flag_reg and ovf_trap are not updated by it. flush has priority over push and pop.
- Reset asserted mid-operation: everything returns to the reset state immediately, and any buffered entries are lost.
- Pointers wrap modulo 2.

Test Plan:
- Reset, then push add in1=5, in2=9, result=14, dest=3, wb_ready=1 -> next cycle wb_valid=1, wb_data=0x000E, wb_dest=3, wb_flags=0000; after the pop flag_reg=0000.
- Push sub 10-7, result=3 -> wb_flags=0000; push sub 5-9, result=0xFFFC -> wb_flags=0110 (N=1, C=1).
- Push add 0x7FFF+0x0001, result=0x8000, trap_en=1 -> wb_flags=0101; ovf_trap pulses one cycle on the pop and flag_reg=0101. Repeat with trap_en=0 -> no pulse. Push add 0xFFFF+0x0001, result=0 -> wb_flags=1010.
- wb_ready=0 with three consecutive in_valid pushes -> in_ready drops after the 2nd push and the 3rd push is held off. Raise wb_ready -> entries pop in order with no loss or duplication. Push and pop in the same cycle at count 1 -> count remains 1.
- Two entries buffered, pulse flush -> wb_valid=0 and in_ready=1 next cycle, flag_reg unchanged. Push with arith_add=arith_sub=0, result=0 -> wb_flags=1000.
- Assert rst low asynchronously between clock edges with 2 entries buffered -> all outputs go to their reset values immediately, before the next edge.
